// File: rtl/galcount_monitor.sv
// Event classifier and count extender for a 4-bit counter, with a threshold
// interrupt that needs an acknowledge and re-arms with hysteresis.
module galcount_monitor #(
  parameter int EXT_W = 4,
  parameter int HYST  = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [3:0]           Q,
  input  logic [EXT_W+3:0]     Thresh,
  input  logic                 Ack,
  output logic [EXT_W+3:0]     Count,
  output logic                 EvInc,
  output logic                 EvWrap,
  output logic                 EvLoad,
  output logic                 EvClr,
  output logic                 Overflow,
  output logic                 Irq
);

  localparam int CW = EXT_W + 4;
  localparam logic [CW-1:0] HYST_C = CW'(HYST);

  localparam logic [1:0] PRIME      = 2'd0;
  localparam logic [1:0] ARMED      = 2'd1;
  localparam logic [1:0] FIRED      = 2'd2;
  localparam logic [1:0] WAIT_REARM = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic [3:0]       prev_reg, prev_next;
  logic [EXT_W-1:0] ext_reg, ext_next;
  logic             inc_reg, inc_next;
  logic             wrap_reg, wrap_next;
  logic             load_reg, load_next;
  logic             clr_reg, clr_next;
  logic             ovf_reg, ovf_next;
  logic             irq_reg, irq_next;

  logic             changed, is_wrap, is_inc, is_clr, is_load;
  logic [CW-1:0]    count_cur, rearm_lim;

  // prev_reg always holds the last sampled Q, so the extended count is just the concatenation
  assign count_cur = {ext_reg, prev_reg};
  assign rearm_lim = (Thresh > HYST_C) ? (Thresh - HYST_C) : '0;

  // 15 -> 0 is always a wrap, even if the upstream counter was actually cleared
  assign changed = (Q != prev_reg);
  assign is_wrap = (prev_reg == 4'hF) && (Q == 4'h0);
  assign is_inc  = changed && (prev_reg != 4'hF) && (Q == prev_reg + 4'd1);
  assign is_clr  = changed && (prev_reg != 4'hF) && (Q == 4'h0);
  assign is_load = changed && !is_wrap && !is_inc && !is_clr;

  always_comb begin
    state_next = state_reg;
    prev_next  = prev_reg;
    ext_next   = ext_reg;
    inc_next   = 1'b0;
    wrap_next  = 1'b0;
    load_next  = 1'b0;
    clr_next   = 1'b0;
    ovf_next   = ovf_reg;
    irq_next   = irq_reg;

    if (state_reg == PRIME) begin
      prev_next  = Q;
      ext_next   = '0;
      irq_next   = 1'b0;
      state_next = ARMED;
    end else begin
      prev_next = Q;
      inc_next  = is_inc;
      wrap_next = is_wrap;
      load_next = is_load;
      clr_next  = is_clr;
      if (is_wrap) begin
        ext_next = ext_reg + EXT_W'(1);
        if (&ext_reg) ovf_next = 1'b1;
      end else if (is_load || is_clr) begin
        ext_next = '0;
      end

      // Interrupt decisions look at the registered count, one cycle behind Q
      case (state_reg)
        ARMED: begin
          if (count_cur >= Thresh) begin
            state_next = FIRED;
            irq_next   = 1'b1;
          end
        end
        FIRED: begin
          if (Ack) begin
            state_next = WAIT_REARM;
            irq_next   = 1'b0;
          end
        end
        WAIT_REARM: begin
          if (count_cur < rearm_lim) state_next = ARMED;
        end
        default: state_next = ARMED;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= PRIME;
      prev_reg  <= '0;
      ext_reg   <= '0;
      inc_reg   <= 1'b0;
      wrap_reg  <= 1'b0;
      load_reg  <= 1'b0;
      clr_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
      irq_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      prev_reg  <= prev_next;
      ext_reg   <= ext_next;
      inc_reg   <= inc_next;
      wrap_reg  <= wrap_next;
      load_reg  <= load_next;
      clr_reg   <= clr_next;
      ovf_reg   <= ovf_next;
      irq_reg   <= irq_next;
    end
  end

  assign Count    = count_cur;
  assign EvInc    = inc_reg;
  assign EvWrap   = wrap_reg;
  assign EvLoad   = load_reg;
  assign EvClr    = clr_reg;
  assign Overflow = ovf_reg;
  assign Irq      = irq_reg;

endmodule

// File: tb/tb_galcount_monitor.sv
// Bench for galcount_monitor: vector table, directed corner sequences and
// random traffic against an arithmetic reference model.
module tb_galcount_monitor;

  localparam int EXT_W = 4;
  localparam int HYST  = 2;
  localparam int CW    = EXT_W + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    q = '0;
  logic [CW-1:0] thresh = '1;
  logic          ack = 1'b0;
  logic [CW-1:0] count;
  logic          ev_inc, ev_wrap, ev_load, ev_clr, overflow, irq;

  int total = 0;
  int bad = 0;

  galcount_monitor #(.EXT_W(EXT_W), .HYST(HYST)) dut (
    .Clock(clk), .Reset(rst), .Q(q), .Thresh(thresh), .Ack(ack),
    .Count(count), .EvInc(ev_inc), .EvWrap(ev_wrap), .EvLoad(ev_load),
    .EvClr(ev_clr), .Overflow(overflow), .Irq(irq)
  );

  always #5 clk = ~clk;

  // Event vector order: {inc, wrap, load, clr}
  localparam logic [3:0] E_NONE = 4'b0000, E_INC = 4'b1000, E_WRAP = 4'b0100,
                         E_LOAD = 4'b0010, E_CLR = 4'b0001;

  // Reference model: count kept as a plain integer high/low split
  int   m_primed;
  int   m_prev, m_ext, m_irqst;   // irqst: 0 armed, 1 fired, 2 waiting to re-arm
  int   m_ovf, m_irq;
  logic [3:0] m_ev;

  function automatic int m_count();
    return m_ext * 16 + m_prev;
  endfunction

  task automatic model(input logic r, input int qi, input int th, input logic a);
    int lim;
    if (r) begin
      m_primed = 0; m_prev = 0; m_ext = 0; m_ovf = 0; m_irq = 0; m_irqst = 0; m_ev = E_NONE;
    end else if (m_primed == 0) begin
      m_primed = 1; m_prev = qi; m_ext = 0; m_ev = E_NONE; m_irq = 0; m_irqst = 0;
    end else begin
      if (m_irqst == 0) begin
        if (m_count() >= th) begin m_irqst = 1; m_irq = 1; end
      end else if (m_irqst == 1) begin
        if (a) begin m_irqst = 2; m_irq = 0; end
      end else begin
        lim = th - HYST;
        if (lim < 0) lim = 0;
        if (m_count() < lim) m_irqst = 0;
      end
      m_ev = E_NONE;
      if (qi != m_prev) begin
        if (m_prev == 15 && qi == 0) begin
          m_ev = E_WRAP;
          if (m_ext == 15) m_ovf = 1;
          m_ext = (m_ext + 1) % 16;
        end else if (qi == m_prev + 1) begin
          m_ev = E_INC;
        end else if (qi == 0) begin
          m_ev = E_CLR; m_ext = 0;
        end else begin
          m_ev = E_LOAD; m_ext = 0;
        end
      end
      m_prev = qi;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [3:0] ev_vec();
    return {ev_inc, ev_wrap, ev_load, ev_clr};
  endfunction

  // One clock: drive, advance the model, sample 1 time unit after the edge, compare
  task automatic step(input logic r, input int qi, input int th, input logic a);
    rst = r; q = 4'(qi); thresh = CW'(th); ack = a;
    model(r, qi, th, a);
    @(posedge clk);
    #1;
    chk("model_count", int'(count), m_count());
    chk("model_ev", int'(ev_vec()), int'(m_ev));
    chk("model_ovf", int'(overflow), m_ovf);
    chk("model_irq", int'(irq), m_irq);
    $display("step r=%0b q=%0d th=0x%0h ack=%0b -> count=0x%0h ev=%b ovf=%0b irq=%0b",
             r, qi, th, a, count, ev_vec(), overflow, irq);
  endtask

  task automatic restart(input int qi);
    step(1'b1, qi, 255, 1'b0);
    step(1'b1, qi, 255, 1'b0);
    step(1'b0, qi, 255, 1'b0);
  endtask

  typedef struct {
    logic       r;
    int         qi;
    int         th;
    logic       a;
    int         e_count;
    logic [3:0] e_ev;
    int         e_ovf;
    int         e_irq;
  } vec_t;

  vec_t vt[15];
  int   incs;

  initial begin
    vt[0]  = '{1'b1, 3, 255, 1'b1, 'h00, E_NONE, 0, 0};
    vt[1]  = '{1'b1, 3, 255, 1'b0, 'h00, E_NONE, 0, 0};
    vt[2]  = '{1'b0, 3, 255, 1'b0, 'h03, E_NONE, 0, 0};
    vt[3]  = '{1'b0, 3, 255, 1'b0, 'h03, E_NONE, 0, 0};
    vt[4]  = '{1'b0, 5, 255, 1'b0, 'h05, E_LOAD, 0, 0};
    vt[5]  = '{1'b0, 9, 255, 1'b0, 'h09, E_LOAD, 0, 0};
    vt[6]  = '{1'b0, 0, 255, 1'b0, 'h00, E_CLR,  0, 0};
    vt[7]  = '{1'b0, 0, 255, 1'b0, 'h00, E_NONE, 0, 0};
    vt[8]  = '{1'b0, 1, 255, 1'b0, 'h01, E_INC,  0, 0};
    vt[9]  = '{1'b0, 2, 255, 1'b0, 'h02, E_INC,  0, 0};
    vt[10] = '{1'b0, 0, 255, 1'b0, 'h00, E_CLR,  0, 0};
    vt[11] = '{1'b0, 0, 0,   1'b0, 'h00, E_NONE, 0, 1};
    vt[12] = '{1'b0, 0, 0,   1'b1, 'h00, E_NONE, 0, 0};
    vt[13] = '{1'b0, 0, 0,   1'b0, 'h00, E_NONE, 0, 0};
    vt[14] = '{1'b0, 0, 0,   1'b1, 'h00, E_NONE, 0, 0};

    for (int i = 0; i < 15; i++) begin
      step(vt[i].r, vt[i].qi, vt[i].th, vt[i].a);
      chk("vec_count", int'(count), vt[i].e_count);
      chk("vec_ev", int'(ev_vec()), int'(vt[i].e_ev));
      chk("vec_ovf", int'(overflow), vt[i].e_ovf);
      chk("vec_irq", int'(irq), vt[i].e_irq);
    end

    // Full lap of Q then wrap, then on to a load and a clear
    restart(0);
    incs = 0;
    for (int i = 1; i < 16; i++) begin
      step(1'b0, i, 255, 1'b0);
      if (ev_inc) incs++;
    end
    chk("lap_incs", incs, 15);
    step(1'b0, 0, 255, 1'b0);
    chk("lap_wrap", int'(ev_wrap), 1);
    chk("lap_count", int'(count), 'h10);
    for (int i = 1; i < 16; i++) step(1'b0, i, 255, 1'b0);
    step(1'b0, 0, 255, 1'b0);
    for (int i = 1; i < 6; i++) step(1'b0, i, 255, 1'b0);
    chk("pre_load_count", int'(count), 'h25);
    step(1'b0, 9, 255, 1'b0);
    chk("load_ev", int'(ev_load), 1);
    chk("load_count", int'(count), 'h09);
    step(1'b0, 0, 255, 1'b0);
    chk("clr_ev", int'(ev_clr), 1);
    chk("clr_count", int'(count), 'h00);

    // Threshold interrupt, acknowledge and hysteresis
    restart(0);
    for (int i = 1; i < 16; i++) step(1'b0, i, 255, 1'b0);
    step(1'b0, 0, 255, 1'b0);
    step(1'b0, 1, 'h12, 1'b0);
    chk("irq_below", int'(irq), 0);
    step(1'b0, 2, 'h12, 1'b0);
    chk("irq_at_thresh_count", int'(count), 'h12);
    chk("irq_latency", int'(irq), 0);
    step(1'b0, 2, 'h12, 1'b0);
    chk("irq_rise", int'(irq), 1);
    step(1'b0, 2, 255, 1'b0);
    chk("irq_hold_thresh_change", int'(irq), 1);
    step(1'b0, 2, 'h12, 1'b1);
    chk("irq_ack", int'(irq), 0);
    step(1'b0, 2, 'h13, 1'b0);
    step(1'b0, 2, 'h13, 1'b0);
    chk("irq_no_rearm", int'(irq), 0);
    step(1'b0, 0, 'h12, 1'b0);
    step(1'b0, 0, 'h12, 1'b0);
    chk("irq_rearm_quiet", int'(irq), 0);
    step(1'b0, 0, 0, 1'b0);
    chk("irq_refire", int'(irq), 1);

    // Sixteen wraps overflow the extension, then reset aborts mid-run
    restart(0);
    for (int w = 0; w < 16; w++) begin
      for (int i = 1; i < 16; i++) step(1'b0, i, 255, 1'b0);
      step(1'b0, 0, 255, 1'b0);
      if (w == 14) begin
        chk("ovf_f0_count", int'(count), 'hF0);
        chk("ovf_f0_flag", int'(overflow), 0);
      end
    end
    chk("ovf_count", int'(count), 'h00);
    chk("ovf_flag", int'(overflow), 1);
    step(1'b0, 1, 0, 1'b0);
    step(1'b0, 2, 0, 1'b0);
    step(1'b1, 5, 0, 1'b1);
    chk("rst_count", int'(count), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_irq", int'(irq), 0);
    step(1'b0, 7, 255, 1'b0);
    chk("prime_count", int'(count), 'h07);
    chk("prime_ev", int'(ev_vec()), 0);

    // Random traffic, mostly increments so wraps and thresholds are reached
    for (int n = 0; n < 3000; n++) begin
      int sel, qn, th;
      logic a, r;
      sel = int'($urandom_range(0, 99));
      if (sel < 55)      qn = (int'(q) + 1) % 16;
      else if (sel < 75) qn = int'(q);
      else               qn = int'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) th = int'($urandom_range(0, 255));
      else                            th = int'(thresh);
      a = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 299) == 0);
      step(r, qn, th, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
